shift_register_universal: RTL
=============================

# shift_register_universal

Parametrised universal shift register: the next generation of our single-bit serial shift register. It adds multi-bit steps, left/right shifting, synchronous parallel load and a frame counter that flags when a loaded word has been fully shifted out. It sits between game-logic word sources and serial peripherals such as LED strips, display column drivers and controller pads, as either a serializer or a deserializer.

## Interface
- WIDTH, 16, register width in bits; must be a multiple of STEP and at least 2.
- STEP, 1, bits moved per shift; 1 ≤ STEP ≤ WIDTH/2.
- RESET_VALUE, 0, WIDTH-bit constant loaded by reset.
- CNT_W, $clog2(WIDTH/STEP+1), width of COUNT.

- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  when 0, all state holds regardless of MODE.
- MODE  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- IN  input  STEP  serial data entering the register.
- LOAD_VALUE  input  WIDTH  word captured on load.
- Q  output  WIDTH  full register contents.
- OUT_MSB  output  STEP  Q[WIDTH-1 -: STEP], the bits leaving on a left shift.
- OUT_LSB  output  STEP  Q[STEP-1:0], the bits leaving on a right shift.
- COUNT  output  CNT_W  shifts remaining in the current frame.
- EMPTY  output  1  COUNT == 0.
- FRAME_DONE  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset (asynchronous, immediate) sets:
  - Q = RESET_VALUE, COUNT = 0, EMPTY = 1, FRAME_DONE = 0.
  - Reset mid-frame discards the frame; no FRAME_DONE is produced.
- Each rising edge with RESET = 0 and ENABLE = 1:
  - MODE 00: Q holds; COUNT holds.
  - MODE 01: Q ← {Q[WIDTH-STEP-1:0], IN}. IN enters at the LSBs; OUT_MSB is lost.
  - MODE 10: Q ← {IN, Q[WIDTH-1:STEP]}. IN enters at the MSBs; OUT_LSB is lost.
  - MODE 11: Q ← LOAD_VALUE; COUNT ← WIDTH/STEP.
- Counter rules:
  - Any shift with COUNT > 0 decrements COUNT.
  - Shifts with COUNT = 0 still move data (free-running use), but COUNT stays 0 and no pulse is generated.
  - A load mid-frame restarts COUNT at WIDTH/STEP; no FRAME_DONE is issued for the aborted frame.
- FRAME_DONE:
  - Registered; high for exactly the one cycle after the edge on which COUNT goes 1 → 0.
  - Otherwise 0. A load on the following edge does not suppress an already-registered pulse.
- ENABLE = 0 freezes Q and COUNT and forces FRAME_DONE to 0 on the next edge.
- Left and right shifts may be mixed within a frame; each one counts as one shift.

## Timing
- Q, COUNT and FRAME_DONE are registered.
- EMPTY, OUT_MSB and OUT_LSB are combinational decodes of registered state; there is no input-to-output combinational path.
- Load-to-Q latency is 1 cycle.
- A full frame takes WIDTH/STEP shift edges after the load edge. FRAME_DONE is visible in the cycle following the last shift edge.
- Back-to-back frames with no bubble: a load in the same cycle FRAME_DONE is high is legal.

## Configuration
- SHIFT_REGISTER_ROTATE_EN defined: adds input ROTATE (1 bit).
  - When ROTATE = 1, MODE 01 feeds OUT_MSB back into the LSBs instead of IN.
  - When ROTATE = 1, MODE 10 feeds OUT_LSB back into the MSBs instead of IN.
  - Counter and FRAME_DONE behave exactly as for normal shifts.
- Not defined: the ROTATE port does not exist; behaviour is identical to ROTATE = 0.

## Test plan
- Reset: WIDTH=16, RESET_VALUE=16'h00FF; assert RESET mid-cycle → Q=00FF, COUNT=0, EMPTY=1 immediately, without waiting for a clock edge.
- Serializer: WIDTH=16, STEP=4; load 16'hA5C3, then 4 left shifts with IN=0 → OUT_MSB sequence A,5,C,3; COUNT 4,3,2,1,0; FRAME_DONE high only in the cycle after the 4th shift; final Q=0000.
- Deserializer: STEP=1, WIDTH=8; load 8'h00, then 8 right shifts with IN=1,0,1,1,0,0,1,0 → Q=8'h4D; exactly one FRAME_DONE pulse.
- Hold and abort: load, 2 shifts, ENABLE=0 for 5 cycles (Q and COUNT frozen), then a reload → COUNT=WIDTH/STEP and no FRAME_DONE for the aborted frame.
- Free-run and back-to-back frames: with COUNT=0, 3 shifts → Q moves, COUNT stays 0, no pulse; then a load in the FRAME_DONE cycle of a completed frame → new frame starts, COUNT=WIDTH/STEP.
- Rotate (macro defined): WIDTH=8, STEP=2; load 8'hB4, ROTATE=1, 4 left shifts → Q returns to B4 after the 4th shift; FRAME_DONE pulses once.

Source files
------------

// File: rtl/shift_register_universal_if.sv
// shift_register_universal_if: control/data bundle for shift_register_universal; SHIFT_REGISTER_ROTATE_EN adds ROTATE
interface shift_register_universal_if #(
    parameter int WIDTH = 16,
    parameter int STEP = 1,
    parameter int CNT_W = $clog2(WIDTH / STEP + 1)
);
    logic             ENABLE;
    logic [1:0]       MODE;
    logic [STEP-1:0]  IN;
    logic [WIDTH-1:0] LOAD_VALUE;
`ifdef SHIFT_REGISTER_ROTATE_EN
    logic             ROTATE;
`endif
    logic [WIDTH-1:0] Q;
    logic [STEP-1:0]  OUT_MSB;
    logic [STEP-1:0]  OUT_LSB;
    logic [CNT_W-1:0] COUNT;
    logic             EMPTY;
    logic             FRAME_DONE;
    modport master (
`ifdef SHIFT_REGISTER_ROTATE_EN
        output ROTATE,
`endif
        output ENABLE, MODE, IN, LOAD_VALUE,
        input Q, OUT_MSB, OUT_LSB, COUNT, EMPTY, FRAME_DONE
    );
    modport slave (
`ifdef SHIFT_REGISTER_ROTATE_EN
        input ROTATE,
`endif
        input ENABLE, MODE, IN, LOAD_VALUE,
        output Q, OUT_MSB, OUT_LSB, COUNT, EMPTY, FRAME_DONE
    );
endinterface

// File: rtl/shift_register_universal.sv
// shift_register_universal: left/right multi-bit shift register with parallel load and frame counter; SHIFT_REGISTER_ROTATE_EN adds rotate
module shift_register_universal #(
    parameter int WIDTH = 16,
    parameter int STEP = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int CNT_W = $clog2(WIDTH / STEP + 1)
) (
    input logic CLK,
    input logic RESET,
    shift_register_universal_if.slave bus
);
    localparam logic [CNT_W-1:0] FRAME = CNT_W'(WIDTH / STEP);
    logic [WIDTH-1:0] q, q_next;
    logic [CNT_W-1:0] count, count_next;
    logic done, shift, load, rotate;
    logic [STEP-1:0] fill_left, fill_right;
`ifdef SHIFT_REGISTER_ROTATE_EN
    assign rotate = bus.ROTATE;
`else
    assign rotate = 1'b0;
`endif
    // next register contents and frame count from mode, enable and rotate selection
    always_comb begin
        shift = bus.ENABLE && (bus.MODE == 2'b01 || bus.MODE == 2'b10);
        load = bus.ENABLE && bus.MODE == 2'b11;
        fill_left = rotate ? q[WIDTH-1 -: STEP] : bus.IN;
        fill_right = rotate ? q[STEP-1:0] : bus.IN;
        q_next = !bus.ENABLE ? q :
                 bus.MODE == 2'b01 ? {q[WIDTH-STEP-1:0], fill_left} :
                 bus.MODE == 2'b10 ? {fill_right, q[WIDTH-1:STEP]} :
                 bus.MODE == 2'b11 ? bus.LOAD_VALUE : q;
        count_next = load ? FRAME : (shift && count != '0) ? count - CNT_W'(1) : count;
    end
    // state register; the done pulse fires on the shift that takes the count from 1 to 0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q <= RESET_VALUE;
            count <= '0;
            done <= 1'b0;
        end else begin
            q <= q_next;
            count <= count_next;
            done <= shift && count == CNT_W'(1);
        end
    end
    assign bus.Q = q;
    assign bus.OUT_MSB = q[WIDTH-1 -: STEP];
    assign bus.OUT_LSB = q[STEP-1:0];
    assign bus.COUNT = count;
    assign bus.EMPTY = count == '0;
    assign bus.FRAME_DONE = done;
endmodule
